// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with phase FSMs and sync/blanking strobes.
// Every output is registered from the same next-position value, so all of them describe one pixel.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic             clk_25mhz,
    input  logic             rst,
    input  logic             pix_en,
    output logic [CNT_W-1:0] h_value,
    output logic [CNT_W-1:0] v_value,
    output logic [1:0]       h_phase,
    output logic [1:0]       v_phase,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_end,
    output logic             frame_start,
    output logic [7:0]       frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
            V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
            longint'(H_TOTAL) > (longint'(1) << CNT_W) ||
            longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_bad_params
            $error("vga_timing_gen: illegal timing parameters");
        end
    endgenerate

    typedef enum logic [1:0] {
        PH_VISIBLE = 2'd0,
        PH_FRONT   = 2'd1,
        PH_SYNC    = 2'd2,
        PH_BACK    = 2'd3
    } phase_t;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_FP_BEG = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] H_SY_BEG = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] H_BP_BEG = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_FP_BEG = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] V_SY_BEG = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] V_BP_BEG = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [CNT_W-1:0] r_h, r_v;
    phase_t           r_h_phase, r_v_phase;
    logic             r_hsync, r_vsync, r_video_on, r_line_end, r_frame_start;
    logic [7:0]       r_frame_count;

    logic             w_h_wrap, w_v_wrap;
    logic [CNT_W-1:0] w_h_next, w_v_next;
    phase_t           w_h_phase_next, w_v_phase_next;

    assign w_h_wrap = (r_h == H_LAST);
    assign w_v_wrap = (r_v == V_LAST);
    assign w_h_next = w_h_wrap ? '0 : r_h + ONE;
    assign w_v_next = w_h_wrap ? (w_v_wrap ? '0 : r_v + ONE) : r_v;

    // Counters step by one, so a phase changes only when the next value hits a range start.
    always_comb begin
        w_h_phase_next = r_h_phase;
        if (w_h_next == '0)           w_h_phase_next = PH_VISIBLE;
        else if (w_h_next == H_FP_BEG) w_h_phase_next = PH_FRONT;
        else if (w_h_next == H_SY_BEG) w_h_phase_next = PH_SYNC;
        else if (w_h_next == H_BP_BEG) w_h_phase_next = PH_BACK;

        w_v_phase_next = r_v_phase;
        if (w_h_wrap) begin
            if (w_v_next == '0)           w_v_phase_next = PH_VISIBLE;
            else if (w_v_next == V_FP_BEG) w_v_phase_next = PH_FRONT;
            else if (w_v_next == V_SY_BEG) w_v_phase_next = PH_SYNC;
            else if (w_v_next == V_BP_BEG) w_v_phase_next = PH_BACK;
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            r_h           <= '0;
            r_v           <= '0;
            r_h_phase     <= PH_VISIBLE;
            r_v_phase     <= PH_VISIBLE;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_video_on    <= 1'b1;
            r_line_end    <= 1'b0;
            r_frame_start <= 1'b1;
            r_frame_count <= 8'd0;
        end else if (pix_en) begin
            r_h           <= w_h_next;
            r_v           <= w_v_next;
            r_h_phase     <= w_h_phase_next;
            r_v_phase     <= w_v_phase_next;
            r_hsync       <= (w_h_phase_next == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= (w_v_phase_next == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
            r_video_on    <= (w_h_phase_next == PH_VISIBLE) && (w_v_phase_next == PH_VISIBLE);
            r_line_end    <= (w_h_next == H_LAST);
            r_frame_start <= (w_h_next == '0) && (w_v_next == '0);
            if (w_h_wrap && w_v_wrap)
                r_frame_count <= r_frame_count + 8'd1;
        end
    end

    assign h_value     = r_h;
    assign v_value     = r_v;
    assign h_phase     = r_h_phase;
    assign v_phase     = r_v_phase;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign line_end    = r_line_end;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule
